// File: rtl/rv32_arb_pkg.sv
// Shared types and constants for the rv32 instruction/data memory arbiter.
// Holds the arbiter state encoding, the RISC-V NOP used as the reset
// instruction, and the default watchdog limit for a single memory transaction.

package rv32_arb_pkg;

  // Arbiter sequencing: data access first, then fetch, then one release cycle.
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    D_REQ  = 3'd1,
    D_WAIT = 3'd2,
    F_REQ  = 3'd3,
    F_WAIT = 3'd4,
    DONE   = 3'd5
  } arb_state_t;

  // addi x0, x0, 0 -- harmless instruction presented before the first fetch.
  localparam logic [31:0] RV32_NOP = 32'h0000_0013;

  // Default number of REQ/WAIT cycles tolerated before a transaction is abandoned.
  localparam logic [7:0] RV32_ARB_TIMEOUT_DEFAULT = 8'd255;

  // True while a memory transaction (request or response phase) is in progress.
  function automatic logic arb_in_transaction(input arb_state_t s);
    return (s == D_REQ) || (s == D_WAIT) || (s == F_REQ) || (s == F_WAIT);
  endfunction

endpackage

// File: rtl/rv32_arb_timeout.sv
// Watchdog counter for one memory transaction of the rv32 arbiter.
// Counts cycles while enabled, restarts on clear, and flags expiry on the
// cycle in which the count of elapsed transaction cycles reaches the limit.

module rv32_arb_timeout (
  input  logic       clk,
  input  logic       rst,
  input  logic       clear,
  input  logic       count_en,
  input  logic [7:0] limit,
  output logic       expired
);

  logic [7:0] count;

  // Cycle counter: clear wins over counting; saturates instead of wrapping.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count <= 8'd0;
    end else if (count_en && (count != 8'hFF)) begin
      count <= count + 8'd1;
    end
  end

  // The current cycle is the limit-th one of the transaction.
  assign expired = count_en && (({1'b0, count} + 9'd1) >= {1'b0, limit});

endmodule

// File: rtl/rv32_mem_arbiter.sv
// rv32_mem_arbiter: shares one single-port, variable-latency memory between
// the core's instruction-fetch port and its data port. Each CPU cycle's
// requests are captured in IDLE, the data access is served before the fetch,
// and the core is stalled until both have completed. Results are presented
// in registered form for one released (DONE) cycle.
//
// Optional feature: define RV32_ARB_TIMEOUT_EN to build in a per-transaction
// watchdog (limit TIMEOUT_CYCLES). On expiry the request is dropped, the
// pending result reads as 0, and the sticky err output is raised until rst.
// Without the macro the arbiter waits indefinitely and err is tied low.

module rv32_mem_arbiter
  import rv32_arb_pkg::*;
#(
  parameter logic [7:0] TIMEOUT_CYCLES = RV32_ARB_TIMEOUT_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  // instruction fetch port
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_ack,
  // data port
  input  logic        d_enable,
  input  logic        d_read,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic [31:0] d_rdata,
  // core stall
  output logic        cpu_stall,
  // memory side
  output logic        mem_valid,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ready,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  // status
  output logic        err
);

  arb_state_t  state;
  logic        pend_d;
  logic        pend_f;
  logic        cap_load;
  logic [31:0] f_addr;

  logic        busy;
  logic        timed_out;
  logic        d_done;
  logic        f_done;
  logic [31:0] d_result;
  logic [31:0] f_result;

  assign busy = arb_in_transaction(state);

  // Stall from the moment a request is seen in IDLE until the DONE cycle.
  assign cpu_stall = (state != DONE) && ((state != IDLE) || if_req || d_enable);

  // Decide whether the pending access finishes this cycle and with what value.
  always_comb begin
    d_done   = 1'b0;
    f_done   = 1'b0;
    d_result = 32'h0;
    f_result = 32'h0;
    case (state)
      D_REQ: begin
        d_done = pend_d && timed_out;
      end
      D_WAIT: begin
        d_done   = pend_d && (mem_rvalid || timed_out);
        d_result = mem_rvalid ? mem_rdata : 32'h0;
      end
      F_REQ: begin
        f_done = pend_f && timed_out;
      end
      F_WAIT: begin
        f_done   = pend_f && (mem_rvalid || timed_out);
        f_result = mem_rvalid ? mem_rdata : 32'h0;
      end
      default: begin
      end
    endcase
  end

`ifdef RV32_ARB_TIMEOUT_EN
  logic tmo_clear;
  logic err_q;

  // Restart the watchdog outside transactions and whenever the data access ends.
  assign tmo_clear = !busy || d_done;

  rv32_arb_timeout u_timeout (
    .clk      (clk),
    .rst      (rst),
    .clear    (tmo_clear),
    .count_en (busy),
    .limit    (TIMEOUT_CYCLES),
    .expired  (timed_out)
  );

  // Sticky error: any expired transaction is remembered until reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= 1'b0;
    end else if (timed_out) begin
      err_q <= 1'b1;
    end
  end

  assign err = err_q;
`else
  assign timed_out = 1'b0;
  // The limit only matters when the watchdog is built in.
  assign err = (TIMEOUT_CYCLES == 8'd0) & 1'b0;
`endif

  // Arbiter FSM with registered memory-side and CPU-side outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      pend_d    <= 1'b0;
      pend_f    <= 1'b0;
      cap_load  <= 1'b0;
      f_addr    <= 32'h0;
      mem_valid <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= 32'h0;
      mem_wdata <= 32'h0;
      d_rdata   <= 32'h0;
      if_rdata  <= RV32_NOP;
      if_ack    <= 1'b0;
    end else begin
      if_ack <= 1'b0;
      case (state)
        IDLE: begin
          if (d_enable || if_req) begin
            pend_d    <= d_enable;
            pend_f    <= if_req;
            cap_load  <= d_read;
            f_addr    <= if_addr;
            mem_valid <= 1'b1;
            if (d_enable) begin
              state     <= D_REQ;
              mem_we    <= ~d_read;
              mem_addr  <= d_addr;
              mem_wdata <= d_wdata;
            end else begin
              state    <= F_REQ;
              mem_we   <= 1'b0;
              mem_addr <= if_addr;
            end
          end
        end

        D_REQ, D_WAIT: begin
          if (d_done) begin
            pend_d <= 1'b0;
            if (cap_load) begin
              d_rdata <= d_result;
            end
            if (pend_f) begin
              state     <= F_REQ;
              mem_valid <= 1'b1;
              mem_we    <= 1'b0;
              mem_addr  <= f_addr;
            end else begin
              state     <= DONE;
              mem_valid <= 1'b0;
            end
          end else if ((state == D_REQ) && mem_ready) begin
            mem_valid <= 1'b0;
            state     <= D_WAIT;
          end
        end

        F_REQ, F_WAIT: begin
          if (f_done) begin
            pend_f    <= 1'b0;
            if_rdata  <= f_result;
            if_ack    <= 1'b1;
            mem_valid <= 1'b0;
            state     <= DONE;
          end else if ((state == F_REQ) && mem_ready) begin
            mem_valid <= 1'b0;
            state     <= F_WAIT;
          end
        end

        DONE: begin
          state <= IDLE;
        end

        default: begin
          state     <= IDLE;
          mem_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rv32_mem_arbiter.sv
// Self-checking bench for rv32_mem_arbiter. A responder plays the memory
// (configurable ready-low cycles and response latency). A transaction-level
// model predicts, from the number of accesses and the memory timing, which
// cycles are stalled, when the result cycle occurs and what values appear;
// a compare process checks the DUT against it every cycle.

module tb_rv32_mem_arbiter;

  localparam logic [31:0] NOP    = 32'h0000_0013;
  localparam int          TB_TMO = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_ack;
  logic        d_enable;
  logic        d_read;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [31:0] d_rdata;
  logic        cpu_stall;
  logic        mem_valid;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ready;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        err;

  rv32_mem_arbiter #(.TIMEOUT_CYCLES(8'd8)) dut (
    .clk        (clk),
    .rst        (rst),
    .if_req     (if_req),
    .if_addr    (if_addr),
    .if_rdata   (if_rdata),
    .if_ack     (if_ack),
    .d_enable   (d_enable),
    .d_read     (d_read),
    .d_addr     (d_addr),
    .d_wdata    (d_wdata),
    .d_rdata    (d_rdata),
    .cpu_stall  (cpu_stall),
    .mem_valid  (mem_valid),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_ready  (mem_ready),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata),
    .err        (err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Memory contents and responder configuration
  logic [31:0] mem [logic [31:0]];
  int cfg_wait = 0;
  int cfg_lat  = 1;

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
  } access_t;
  access_t exp_q[$];

  // Transaction model: current slot (m_*) and the previous one (p_*)
  logic chk_en = 1'b0;
  int   t_start = 0, t_done = 0, p_done = -1;
  logic m_fetch = 1'b0, m_load = 1'b0, m_to = 1'b0;
  logic p_fetch = 1'b0, p_load = 1'b0, p_to = 1'b0;
  logic [31:0] m_if_val = 0, m_d_val = 0, p_if_val = 0, p_d_val = 0;
  logic [31:0] exp_if = NOP, exp_d = 0;
  logic        exp_err = 1'b0;

  function automatic logic [31:0] memRead(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return 32'h0;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  // Advance to the negative edge of cycle n.
  task automatic gotoNeg(input int n);
    do @(negedge clk); while (cyc < n);
  endtask

  // Issue one CPU request and predict its result cycle and values.
  task automatic applyStimulus(input logic fe, input logic [31:0] fa,
                               input logic de, input logic rd,
                               input logic [31:0] da, input logic [31:0] wd,
                               input int w, input int lat, input logic tmo,
                               input int skew, input int hold);
    int n;
    int per;
    access_t a;
    @(posedge clk); #2;
    p_done = t_done; p_fetch = m_fetch; p_load = m_load; p_to = m_to;
    p_if_val = m_if_val; p_d_val = m_d_val;
    cfg_wait = w;
    cfg_lat  = lat;
    n = 0;
    m_load = 1'b0;
    m_fetch = 1'b0;
    m_to = tmo;
    if (de) begin
      n++;
      a.addr = da; a.we = ~rd; a.wdata = wd;
      exp_q.push_back(a);
      m_load = rd;
      m_d_val = rd ? memRead(da) : 32'h0;
    end
    if (fe) begin
      n++;
      if (!tmo) begin
        a.addr = fa; a.we = 1'b0; a.wdata = 32'h0;
        exp_q.push_back(a);
      end
      m_fetch = 1'b1;
      m_if_val = tmo ? 32'h0 : memRead(fa);
    end
    per = tmo ? TB_TMO : (1 + w + lat);
    t_start = cyc + skew;
    t_done  = t_start + 1 + n * per;
    if_req = fe; if_addr = fa;
    d_enable = de; d_read = rd; d_addr = da; d_wdata = wd;
    repeat (hold) begin
      @(posedge clk); #2;
    end
    if_req = 1'b0;
    d_enable = 1'b0;
  endtask

  // Memory responder: ready-low stretching, latency, and request-hold checks.
  initial begin : responder
    logic        acc_prev, prev_valid, vld;
    logic [31:0] acc_addr, acc_wdata, prev_addr, prev_wdata, rsp_data;
    logic        acc_we, prev_we;
    int          rsp_cnt, low_cnt;
    access_t     e;
    acc_prev = 0; prev_valid = 0; rsp_cnt = 0; low_cnt = 0;
    acc_addr = 0; acc_wdata = 0; acc_we = 0; prev_addr = 0; prev_wdata = 0; prev_we = 0;
    rsp_data = 0;
    mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h0;
    forever begin
      @(negedge clk);
      mem_rvalid = 1'b0;
      vld = (mem_valid === 1'b1);
      if (acc_prev) begin
        if (exp_q.size() == 0) begin
          checkOutput("access_expected", 32'd0, 32'd1);
        end else begin
          e = exp_q.pop_front();
          checkOutput("access_addr", acc_addr, e.addr);
          checkOutput("access_we", {31'd0, acc_we}, {31'd0, e.we});
          if (e.we) checkOutput("access_wdata", acc_wdata, e.wdata);
        end
        if (acc_we) begin
          mem[acc_addr] = acc_wdata;
          rsp_data = 32'h0;
        end else begin
          rsp_data = memRead(acc_addr);
        end
        rsp_cnt = cfg_lat;
      end
      if (rsp_cnt > 0) begin
        rsp_cnt--;
        if (rsp_cnt == 0) begin
          mem_rvalid = 1'b1;
          mem_rdata  = rsp_data;
        end
      end
      if (vld && prev_valid && !acc_prev) begin
        checkOutput("hold_addr", mem_addr, prev_addr);
        checkOutput("hold_wdata", mem_wdata, prev_wdata);
        checkOutput("hold_we", {31'd0, mem_we}, {31'd0, prev_we});
      end
      if (!vld) low_cnt = 0;
      mem_ready = vld && (low_cnt >= cfg_wait);
      if (vld && !mem_ready) low_cnt++;
      acc_prev   = vld && mem_ready;
      acc_addr   = mem_addr;  acc_we  = mem_we;  acc_wdata  = mem_wdata;
      prev_valid = vld;
      prev_addr  = mem_addr;  prev_we = mem_we;  prev_wdata = mem_wdata;
    end
  end

  // Per-cycle comparison of the DUT against the transaction model.
  initial begin : compare
    forever begin
      @(negedge clk);
      if (chk_en) begin
        if (cyc == p_done) begin
          if (p_fetch) exp_if = p_if_val;
          if (p_load)  exp_d  = p_d_val;
          if (p_to)    exp_err = 1'b1;
        end
        if (cyc == t_done) begin
          if (m_fetch) exp_if = m_if_val;
          if (m_load)  exp_d  = m_d_val;
          if (m_to)    exp_err = 1'b1;
        end
        checkOutput("cpu_stall", {31'd0, cpu_stall},
                    {31'd0, (cyc >= t_start) && (cyc < t_done)});
        checkOutput("if_ack", {31'd0, if_ack},
                    {31'd0, ((cyc == t_done) && m_fetch) || ((cyc == p_done) && p_fetch)});
        if ((cyc <= t_start) || (cyc >= t_done)) begin
          checkOutput("if_rdata", if_rdata, exp_if);
          checkOutput("d_rdata", d_rdata, exp_d);
        end
        checkOutput("err", {31'd0, err}, {31'd0, exp_err});
      end
    end
  end

  initial begin : watchdog
    #400000;
    errors++;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin : main
    int t0;
    rst = 1'b1; if_req = 0; if_addr = 0; d_enable = 0; d_read = 0; d_addr = 0; d_wdata = 0;
    mem[32'h100]  = 32'hDEADBEEF;
    mem[32'h104]  = 32'h00500093;
    mem[32'h108]  = 32'h00A00113;
    mem[32'h10C]  = 32'h0000006F;
    mem[32'h110]  = 32'h00100073;
    mem[32'h2000] = 32'hCAFE0001;
    mem[32'h2400] = 32'hA5A5A5A5;

    // Reset values
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_mem_valid", {31'd0, mem_valid}, 32'd0);
    checkOutput("rst_mem_we", {31'd0, mem_we}, 32'd0);
    checkOutput("rst_mem_addr", mem_addr, 32'h0);
    checkOutput("rst_mem_wdata", mem_wdata, 32'h0);
    checkOutput("rst_d_rdata", d_rdata, 32'h0);
    checkOutput("rst_if_rdata", if_rdata, 32'h0000_0013);
    checkOutput("rst_if_ack", {31'd0, if_ack}, 32'd0);
    checkOutput("rst_err", {31'd0, err}, 32'd0);
    checkOutput("rst_stall", {31'd0, cpu_stall}, 32'd0);
    @(posedge clk); #2;
    rst = 1'b0;
    chk_en = 1'b1;

    // Fetch only, zero-wait memory
    applyStimulus(1, 32'h100, 0, 0, 0, 0, 0, 1, 0, 0, 1);
    t0 = t_start;
    @(negedge clk);
    checkOutput("fetch_valid_c2", {31'd0, mem_valid}, 32'd1);
    checkOutput("fetch_addr_c2", mem_addr, 32'h100);
    gotoNeg(t_done);
    checkOutput("fetch_rdata", if_rdata, 32'hDEADBEEF);
    checkOutput("fetch_ack", {31'd0, if_ack}, 32'd1);
    checkOutput("fetch_stall_done", {31'd0, cpu_stall}, 32'd0);
    checkOutput("fetch_len", t_done - t0, 32'd3);

    // Load + fetch in the same cycle: data first
    applyStimulus(1, 32'h104, 1, 1, 32'h2000, 0, 0, 1, 0, 0, 1);
    t0 = t_start;
    @(negedge clk);
    checkOutput("lf_first_addr", mem_addr, 32'h2000);
    checkOutput("lf_first_we", {31'd0, mem_we}, 32'd0);
    gotoNeg(t0 + 3);
    checkOutput("lf_second_addr", mem_addr, 32'h104);
    checkOutput("lf_second_valid", {31'd0, mem_valid}, 32'd1);
    gotoNeg(t_done);
    checkOutput("lf_d_rdata", d_rdata, 32'hCAFE0001);
    checkOutput("lf_if_rdata", if_rdata, 32'h00500093);
    checkOutput("lf_len", t_done - t0, 32'd5);

    // Store with mem_ready low for 3 cycles
    applyStimulus(0, 0, 1, 0, 32'h3000, 32'h12345678, 3, 1, 0, 0, 1);
    t0 = t_start;
    @(negedge clk);
    checkOutput("st_we", {31'd0, mem_we}, 32'd1);
    checkOutput("st_addr", mem_addr, 32'h3000);
    checkOutput("st_wdata", mem_wdata, 32'h12345678);
    gotoNeg(t0 + 4);
    checkOutput("st_addr_late", mem_addr, 32'h3000);
    checkOutput("st_wdata_late", mem_wdata, 32'h12345678);
    gotoNeg(t_done);
    checkOutput("st_d_rdata_kept", d_rdata, 32'hCAFE0001);
    checkOutput("st_len", t_done - t0, 32'd6);

    // Load back with fetch, slow memory
    applyStimulus(1, 32'h108, 1, 1, 32'h3000, 0, 1, 3, 0, 0, 1);
    t0 = t_start;
    gotoNeg(t_done);
    checkOutput("slow_d_rdata", d_rdata, 32'h12345678);
    checkOutput("slow_len", t_done - t0, 32'd11);

    // Store + fetch
    applyStimulus(1, 32'h10C, 1, 0, 32'h3004, 32'hFEEDF00D, 0, 2, 0, 0, 1);
    gotoNeg(t_done - 1);

    // Request raised during DONE is taken in the following IDLE cycle
    applyStimulus(1, 32'h110, 0, 0, 0, 0, 0, 1, 0, 1, 2);
    gotoNeg(p_done);
    checkOutput("sf_if_rdata", if_rdata, 32'h0000006F);
    checkOutput("sf_d_rdata", d_rdata, 32'h12345678);
    gotoNeg(t_done);
    checkOutput("defer_if_rdata", if_rdata, 32'h00100073);
    checkOutput("defer_len", t_done - p_done, 32'd4);
    gotoNeg(t_done + 1);

    // Reset during D_WAIT with the response arriving one cycle later
    @(posedge clk); #2;
    chk_en = 1'b0;
    applyStimulus(0, 0, 1, 1, 32'h2400, 0, 0, 2, 0, 0, 1);
    t0 = t_start;
    gotoNeg(t0 + 2);
    checkOutput("rw_in_wait_stall", {31'd0, cpu_stall}, 32'd1);
    checkOutput("rw_in_wait_valid", {31'd0, mem_valid}, 32'd0);
    rst = 1'b1;
    @(posedge clk); #2;
    rst = 1'b0;
    @(negedge clk);
    checkOutput("rw_idle_stall", {31'd0, cpu_stall}, 32'd0);
    checkOutput("rw_idle_valid", {31'd0, mem_valid}, 32'd0);
    @(negedge clk);
    checkOutput("rw_d_rdata", d_rdata, 32'h0);
    checkOutput("rw_if_rdata", if_rdata, 32'h0000_0013);
    checkOutput("rw_if_ack", {31'd0, if_ack}, 32'd0);
    @(posedge clk); #2;
    exp_d = 32'h0; exp_if = NOP; exp_err = 1'b0;
    t_start = 0; t_done = 0; p_done = -1;
    m_fetch = 0; m_load = 0; m_to = 0;
    chk_en = 1'b1;

    // Recovery after reset
    applyStimulus(1, 32'h104, 0, 0, 0, 0, 0, 1, 0, 0, 1);
    gotoNeg(t_done);
    checkOutput("recover_if_rdata", if_rdata, 32'h00500093);
    gotoNeg(t_done + 1);

`ifdef RV32_ARB_TIMEOUT_EN
    // Fetch that the memory never accepts
    applyStimulus(1, 32'h100, 0, 0, 0, 0, 1000, 1, 1, 0, 1);
    t0 = t_start;
    gotoNeg(t0 + 8);
    checkOutput("to_err_before", {31'd0, err}, 32'd0);
    checkOutput("to_valid_before", {31'd0, mem_valid}, 32'd1);
    gotoNeg(t_done);
    checkOutput("to_err", {31'd0, err}, 32'd1);
    checkOutput("to_if_rdata", if_rdata, 32'h0);
    checkOutput("to_if_ack", {31'd0, if_ack}, 32'd1);
    checkOutput("to_valid_dropped", {31'd0, mem_valid}, 32'd0);
    checkOutput("to_len", t_done - t0, 32'd9);
    gotoNeg(t_done + 5);
    checkOutput("to_err_sticky", {31'd0, err}, 32'd1);
    @(posedge clk); #2;
    chk_en = 1'b0;
    cfg_wait = 0;
    rst = 1'b1;
    @(posedge clk); #2;
    rst = 1'b0;
    @(negedge clk);
    checkOutput("to_err_cleared", {31'd0, err}, 32'd0);
`endif

    @(posedge clk); #2;
    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
